// File: rtl/data_mem_responder_if.sv
// Load/store handshake between the core memory-access stage and the wait-state data memory.
// The master side (core) holds req and the access fields until it sees ack.
interface data_mem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;
    logic        addr_err;
    logic        busy;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, addr_err, busy
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, addr_err, busy
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-wide data memory that answers one access per WAIT_CYCLES+2 cycles with a one-cycle ack,
// so core stall logic can be exercised against slow memory.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] ADDR_BASE   = 32'h0
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack, busy;

    logic               lat_we;
    logic [31:0]        lat_addr, lat_wdata;

    logic               acc_we;
    logic [31:0]        acc_addr, acc_wdata;
    logic [29:0]        acc_index;
    logic               acc_err, acc_fire;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        rdata_q;
    logic               err_q;

    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack     = 1'b0;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                busy  = 1'b1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                busy    = 1'b1;
                ack     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the access happens on the sampling edge, before
    // the fields are latched, so the live bus fields are used directly.
    always_comb begin
        acc_we    = lat_we;
        acc_addr  = lat_addr;
        acc_wdata = lat_wdata;
        if (state_q == S_IDLE) begin
            acc_we    = bus.we;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
        end
        acc_index = 30'((acc_addr - ADDR_BASE) >> 2);
        acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr < ADDR_BASE) ||
                    (acc_index >= 30'(DEPTH_WORDS));
        acc_fire  = (state_d == S_RESP) && (state_q != S_RESP);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && bus.req) begin
                lat_we    <= bus.we;
                lat_addr  <= bus.addr;
                lat_wdata <= bus.wdata;
            end
        end
    end

    // NOTE: the storage is cleared by reset, which forces it into flops rather
    // than a RAM macro; an aborted store must leave nothing behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem[i] <= '0;
            end
        end else if (acc_fire && acc_we && !acc_err) begin
            mem[acc_index[IDX_W-1:0]] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (acc_fire) begin
            err_q <= acc_err;
            if (acc_err) begin
                rdata_q <= '0;
            end else if (!acc_we) begin
                rdata_q <= mem[acc_index[IDX_W-1:0]];
            end
        end
    end

    assign bus.ack      = ack;
    assign bus.busy     = busy;
    assign bus.rdata    = rdata_q;
    assign bus.addr_err = ack && err_q;

endmodule
